// File: rtl/ranger_pkg.sv
// Shared types and default constants for the ultrasonic range sequencer.
package ranger_pkg;

   // Measurement sequencer states
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      TRIG      = 3'd1,
      WAIT_RISE = 3'd2,
      MEASURE   = 3'd3,
      DONE      = 3'd4,
      HOLDOFF   = 3'd5
   } state_e;

   // Defaults for a 50 MHz clock
   localparam int unsigned DEF_TRIG_CYCLES   = 500;
   localparam int unsigned DEF_CYCLES_PER_CM = 2915;
   localparam int unsigned DEF_MAX_CM        = 400;
   localparam int unsigned DEF_ECHO_TIMEOUT  = 1250000;
   localparam int unsigned DEF_PERIOD_CYCLES = 3000000;

   // Width of a counter that runs 0..n-1 (at least one bit)
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous pin plus registered rise/fall strobes.
// A pin edge shows up on rise/fall three clocks later.
module sync_edge (
   input  logic clock,
   input  logic RESET_N,
   input  logic async_in,
   output logic rise,
   output logic fall
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;
   logic rise_q, rise_d;
   logic fall_q, fall_d;

   // Next-state: shift the pin through the synchroniser and compare adjacent samples
   always_comb begin
      meta_d = async_in;
      sync_d = meta_q;
      prev_d = sync_q;
      rise_d = sync_q & ~prev_q;
      fall_d = ~sync_q & prev_q;
   end

   // Synchroniser and strobe registers
   always_ff @(posedge clock or negedge RESET_N) begin
      if (!RESET_N) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign rise = rise_q;
   assign fall = fall_q;

endmodule

// File: rtl/ultrasonic_range_sequencer.sv
// HC-SR04-style ranger: periodic trigger pulse, echo timing, conversion to whole cm.
// Results are registered on the transition into DONE so distance and dist_valid
// appear together for exactly one clock.
module ultrasonic_range_sequencer
   import ranger_pkg::*;
#(
   parameter int unsigned TRIG_CYCLES   = DEF_TRIG_CYCLES,
   parameter int unsigned CYCLES_PER_CM = DEF_CYCLES_PER_CM,
   parameter int unsigned MAX_CM        = DEF_MAX_CM,
   parameter int unsigned ECHO_TIMEOUT  = DEF_ECHO_TIMEOUT,
   parameter int unsigned PERIOD_CYCLES = DEF_PERIOD_CYCLES
) (
   input  logic        clock,
   input  logic        RESET_N,
   input  logic        enable,
   input  logic        echo,
   output logic        trig,
   output logic [31:0] distance,
   output logic        dist_valid,
   output logic        timeout,
   output logic        busy
);

   localparam int unsigned PW = cnt_width(PERIOD_CYCLES);
   localparam int unsigned TW = cnt_width(ECHO_TIMEOUT);
   localparam int unsigned KW = cnt_width(CYCLES_PER_CM);
   localparam int unsigned CW = $clog2(MAX_CM + 1);

   localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYCLES - 1);
   localparam logic [PW-1:0] TRIG_LAST   = PW'(TRIG_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST    = TW'(ECHO_TIMEOUT - 1);
   localparam logic [KW-1:0] TICK_LAST   = KW'(CYCLES_PER_CM - 1);
   localparam logic [CW-1:0] CM_MAX      = CW'(MAX_CM);

   state_e        state_q, state_d;
   logic [PW-1:0] period_q, period_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [KW-1:0] tick_q, tick_d;
   logic [CW-1:0] cm_q, cm_d;
   logic [CW-1:0] dist_q, dist_d;
   logic [CW-1:0] cm_meas;
   logic          trig_q, trig_d;
   logic          valid_q, valid_d;
   logic          tmo_flag_q, tmo_flag_d;
   logic          echo_rise, echo_fall;

   sync_edge u_sync_edge (
      .clock    (clock),
      .RESET_N  (RESET_N),
      .async_in (echo),
      .rise     (echo_rise),
      .fall     (echo_fall)
   );

   // Range including the current echo clock, so N full cm-periods of echo report N
   assign cm_meas = (tick_q == TICK_LAST && cm_q != CM_MAX) ? cm_q + 1'b1 : cm_q;

   // Sequencer next-state, counters and result capture
   always_comb begin
      state_d    = state_q;
      period_d   = period_q;
      tmo_d      = tmo_q;
      tick_d     = tick_q;
      cm_d       = cm_q;
      dist_d     = dist_q;
      valid_d    = 1'b0;
      tmo_flag_d = tmo_flag_q;

      // Period counter is held at 0 in IDLE so TRIG entry starts the period at 0
      if (state_q == IDLE) begin
         period_d = '0;
      end else begin
         period_d = (period_q == PERIOD_LAST) ? '0 : period_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (enable) state_d = TRIG;
         end
         TRIG: begin
            if (period_q == TRIG_LAST) begin
               state_d = WAIT_RISE;
               tmo_d   = '0;
            end
         end
         WAIT_RISE: begin
            tmo_d = tmo_q + 1'b1;
            if (echo_rise) begin
               state_d = MEASURE;
               tmo_d   = '0;
               tick_d  = '0;
               cm_d    = '0;
            end else if (tmo_q == TMO_LAST) begin
               state_d    = DONE;
               dist_d     = CM_MAX;
               tmo_flag_d = 1'b1;
               valid_d    = 1'b1;
            end
         end
         MEASURE: begin
            tmo_d = tmo_q + 1'b1;
            if (tick_q == TICK_LAST) begin
               tick_d = '0;
               if (cm_q != CM_MAX) cm_d = cm_q + 1'b1;
            end else begin
               tick_d = tick_q + 1'b1;
            end
            // A real echo fall takes priority over any simultaneous limit
            if (echo_fall) begin
               state_d    = DONE;
               dist_d     = cm_meas;
               tmo_flag_d = 1'b0;
               valid_d    = 1'b1;
            end else if (tmo_q == TMO_LAST || cm_q == CM_MAX) begin
               state_d    = DONE;
               dist_d     = CM_MAX;
               tmo_flag_d = 1'b1;
               valid_d    = 1'b1;
            end
         end
         DONE: begin
            state_d = HOLDOFF;
         end
         HOLDOFF: begin
            if (period_q == PERIOD_LAST) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      trig_d = (state_d == TRIG);
   end

   // State, counter and output registers
   always_ff @(posedge clock or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= IDLE;
         period_q   <= '0;
         tmo_q      <= '0;
         tick_q     <= '0;
         cm_q       <= '0;
         dist_q     <= CM_MAX;
         trig_q     <= 1'b0;
         valid_q    <= 1'b0;
         tmo_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         period_q   <= period_d;
         tmo_q      <= tmo_d;
         tick_q     <= tick_d;
         cm_q       <= cm_d;
         dist_q     <= dist_d;
         trig_q     <= trig_d;
         valid_q    <= valid_d;
         tmo_flag_q <= tmo_flag_d;
      end
   end

   assign trig       = trig_q;
   assign distance   = 32'(dist_q);
   assign dist_valid = valid_q;
   assign timeout    = tmo_flag_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ultrasonic_range_sequencer.sv
// Directed bench for the ranger at scaled timing (TRIG 4, 10 clk/cm, max 20 cm,
// timeout 300, period 800). Inputs driven and outputs sampled on the falling edge.
module tb_ultrasonic_range_sequencer;

   logic        clock;
   logic        RESET_N;
   logic        enable;
   logic        echo;
   logic        trig;
   logic [31:0] distance;
   logic        dist_valid;
   logic        timeout;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   ultrasonic_range_sequencer #(
      .TRIG_CYCLES   (4),
      .CYCLES_PER_CM (10),
      .MAX_CM        (20),
      .ECHO_TIMEOUT  (300),
      .PERIOD_CYCLES (800)
   ) dut (
      .clock      (clock),
      .RESET_N    (RESET_N),
      .enable     (enable),
      .echo       (echo),
      .trig       (trig),
      .distance   (distance),
      .dist_valid (dist_valid),
      .timeout    (timeout),
      .busy       (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   // Wait for trig high; returns the cycle stamp of the first high sample
   task automatic wait_trig_rise(output int t);
      int n;
      n = 0;
      t = 0;
      while (n < 2000) begin
         @(negedge clock);
         if (trig) break;
         n++;
      end
      if (n >= 2000) check("trig_rise_wait", 32'd0, 32'd1);
      t = cyc;
   endtask

   // Count consecutive high samples of trig, returning at the first low sample
   task automatic wait_trig_fall(output int len);
      len = 1;
      while (len < 2000) begin
         @(negedge clock);
         if (!trig) break;
         len++;
      end
      if (len >= 2000) check("trig_fall_wait", 32'd0, 32'd1);
   endtask

   // Number of falling edges until dist_valid is seen
   task automatic count_to_valid(input int limit, output int k);
      k = 0;
      while (k < limit) begin
         @(negedge clock);
         k++;
         if (dist_valid) break;
      end
      if (!dist_valid) check("valid_wait", 32'd0, 32'd1);
   endtask

   initial begin
      int t0, t1, len, k, hi;

      RESET_N = 1'b0;
      enable  = 1'b0;
      echo    = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_trig", {31'd0, trig}, 32'd0);
      check("rst_distance", distance, 32'd20);
      check("rst_valid", {31'd0, dist_valid}, 32'd0);
      check("rst_timeout", {31'd0, timeout}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);

      // Measurement 1: 155-clock echo -> 15 cm
      RESET_N = 1'b1;
      enable  = 1'b1;
      wait_trig_rise(t0);
      check("pre_distance", distance, 32'd20);
      check("pre_valid", {31'd0, dist_valid}, 32'd0);
      wait_trig_fall(len);
      check("trig_len", len, 32'd4);
      echo = 1'b1;
      repeat (155) @(negedge clock);
      echo = 1'b0;
      count_to_valid(20, k);
      check("fall_to_valid", k, 32'd4);
      check("m1_distance", distance, 32'd15);
      check("m1_timeout", {31'd0, timeout}, 32'd0);
      @(negedge clock);
      check("m1_single_strobe", {31'd0, dist_valid}, 32'd0);
      check("m1_busy_holdoff", {31'd0, busy}, 32'd1);

      // Measurement 2: no echo -> timeout after 300 clocks in WAIT_RISE
      wait_trig_rise(t1);
      check("period", t1 - t0, 32'd801);
      wait_trig_fall(len);
      count_to_valid(400, k);
      check("no_echo_wait", k, 32'd300);
      check("no_echo_distance", distance, 32'd20);
      check("no_echo_timeout", {31'd0, timeout}, 32'd1);

      // Measurement 3: echo held 250 clocks -> saturates at 20 cm
      wait_trig_rise(t0);
      wait_trig_fall(len);
      echo = 1'b1;
      k = 0;
      for (int i = 1; i <= 250; i++) begin
         @(negedge clock);
         if (dist_valid && k == 0) begin
            k = i;
            check("sat_distance", distance, 32'd20);
            check("sat_timeout", {31'd0, timeout}, 32'd1);
         end
      end
      echo = 1'b0;
      check("sat_valid_at", k, 32'd205);
      repeat (10) @(negedge clock);
      check("sat_no_wrap", distance, 32'd20);

      // Measurement 4: enable dropped mid-echo; 105-clock echo -> 10 cm, then stop
      wait_trig_rise(t0);
      wait_trig_fall(len);
      echo = 1'b1;
      repeat (20) @(negedge clock);
      enable = 1'b0;
      repeat (85) @(negedge clock);
      echo = 1'b0;
      count_to_valid(20, k);
      check("en_drop_valid_at", k, 32'd4);
      check("en_drop_distance", distance, 32'd10);
      check("en_drop_timeout", {31'd0, timeout}, 32'd0);
      k = 0;
      while (busy && k < 1000) begin
         @(negedge clock);
         k++;
      end
      check("busy_span", cyc - t0, 32'd800);
      hi = 0;
      repeat (900) begin
         @(negedge clock);
         if (trig || busy) hi++;
      end
      check("stopped_no_trig", hi, 32'd0);
      check("stopped_distance", distance, 32'd10);

      // Reset pulse in the middle of a trigger pulse
      enable = 1'b1;
      wait_trig_rise(t0);
      @(negedge clock);
      RESET_N = 1'b0;
      #1;
      check("rst_mid_trig", {31'd0, trig}, 32'd0);
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_distance", distance, 32'd20);
      @(negedge clock);
      enable  = 1'b0;
      RESET_N = 1'b1;
      hi = 0;
      repeat (10) begin
         @(negedge clock);
         if (trig || busy) hi++;
      end
      check("rst_mid_idle", hi, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
